// File: rtl/add_relu_framer.sv
// add_relu_framer: registered ReLU output stage with feature-map framing markers.
// Optional ReLU is enabled by defining ADD_RELU_FRAMER_RELU_EN.
`default_nettype none

module add_relu_framer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IMAGE_SIZE  = 612*612,
  parameter int NUM_CHANNEL = 4,
  parameter int PIX_WIDTH   = 19,
  parameter int CH_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sof,
  output logic                  eoc,
  output logic                  eof,
  output logic [CH_WIDTH-1:0]   ch_idx,
  output logic                  done
);

  localparam logic [PIX_WIDTH-1:0] PIX_LAST = PIX_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CH_WIDTH-1:0]  CH_LAST  = CH_WIDTH'(NUM_CHANNEL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PIX_WIDTH-1:0]  pix_cnt;
  logic [PIX_WIDTH-1:0]  pix_nxt;
  logic [CH_WIDTH-1:0]   ch_cnt;
  logic [CH_WIDTH-1:0]   ch_nxt;
  logic                  beat;
  logic                  pix_last;
  logic                  ch_last;
  logic                  sof_nxt;
  logic                  eoc_nxt;
  logic                  eof_nxt;
  logic                  done_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;

  // A beat coinciding with clear is dropped, so clear gates acceptance.
  assign beat     = valid_in & ~clear;
  assign pix_last = (pix_cnt == PIX_LAST);
  assign ch_last  = (ch_cnt == CH_LAST);

`ifdef ADD_RELU_FRAMER_RELU_EN
  // Any set sign bit (negatives, -0.0, negative NaN) clamps to +0.0.
  assign data_nxt = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
  assign data_nxt = data_in;
`endif

  always_comb begin
    state_nxt = state;
    pix_nxt   = pix_cnt;
    ch_nxt    = ch_cnt;
    sof_nxt   = 1'b0;
    eoc_nxt   = 1'b0;
    eof_nxt   = 1'b0;
    done_nxt  = 1'b0;

    if (clear) begin
      state_nxt = IDLE;
      pix_nxt   = '0;
      ch_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            sof_nxt   = 1'b1;
            pix_nxt   = PIX_WIDTH'(1);
            ch_nxt    = '0;
            state_nxt = RUN;
          end
        end

        DONE: begin
          done_nxt = 1'b1;
          if (beat) begin
            sof_nxt   = 1'b1;
            pix_nxt   = PIX_WIDTH'(1);
            ch_nxt    = '0;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end

        RUN: begin
          if (beat) begin
            if (pix_last) begin
              eoc_nxt = 1'b1;
              pix_nxt = '0;
              if (ch_last) begin
                eof_nxt   = 1'b1;
                ch_nxt    = '0;
                state_nxt = DONE;
              end else begin
                ch_nxt = ch_cnt + CH_WIDTH'(1);
              end
            end else begin
              pix_nxt = pix_cnt + PIX_WIDTH'(1);
            end
          end
        end

        default: begin
          state_nxt = IDLE;
          pix_nxt   = '0;
          ch_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pix_cnt <= '0;
      ch_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      pix_cnt <= pix_nxt;
      ch_cnt  <= ch_nxt;
    end
  end

  // Output flops: markers and valid are qualified per cycle; data and ch_idx hold between beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      sof       <= 1'b0;
      eoc       <= 1'b0;
      eof       <= 1'b0;
      ch_idx    <= '0;
      done      <= 1'b0;
    end else begin
      valid_out <= beat;
      sof       <= sof_nxt;
      eoc       <= eoc_nxt;
      eof       <= eof_nxt;
      done      <= done_nxt;
      if (beat) begin
        data_out <= data_nxt;
        ch_idx   <= ch_cnt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_relu_framer.sv
// tb_add_relu_framer: directed and random checks of add_relu_framer against a frame-index model.
`default_nettype none

module tb_add_relu_framer;

  localparam int DW    = 32;
  localparam int IS    = 4;
  localparam int NC    = 2;
  localparam int FRAME = IS * NC;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          sof;
  logic          eoc;
  logic          eof;
  logic [7:0]    ch_idx;
  logic          done;

  add_relu_framer #(
    .DATA_WIDTH (DW),
    .IMAGE_SIZE (IS),
    .NUM_CHANNEL(NC),
    .PIX_WIDTH  (3),
    .CH_WIDTH   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .valid_in (valid_in),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .sof      (sof),
    .eoc      (eoc),
    .eof      (eof),
    .ch_idx   (ch_idx),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: position of the next accepted beat within its frame.
  int            k        = 0;
  logic          last_eof = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_valid = 1'b0;
  logic          exp_sof  = 1'b0;
  logic          exp_eoc  = 1'b0;
  logic          exp_eof  = 1'b0;
  logic [7:0]    exp_ch   = '0;
  logic          exp_done = 1'b0;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef ADD_RELU_FRAMER_RELU_EN
    return x[DW-1] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    check("data_out",  data_out,         exp_data);
    check("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
    check("sof",       {31'b0, sof},     {31'b0, exp_sof});
    check("eoc",       {31'b0, eoc},     {31'b0, exp_eoc});
    check("eof",       {31'b0, eof},     {31'b0, exp_eof});
    check("ch_idx",    {24'b0, ch_idx},  {24'b0, exp_ch});
    check("done",      {31'b0, done},    {31'b0, exp_done});
  endtask

  task automatic model_reset();
    k = 0; last_eof = 1'b0;
    exp_data = '0; exp_valid = 1'b0; exp_sof = 1'b0; exp_eoc = 1'b0;
    exp_eof = 1'b0; exp_ch = '0; exp_done = 1'b0;
  endtask

  // One clock: drive inputs, advance the model for the edge, compare outputs 1ns after it.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic c);
    valid_in = v; data_in = d; clear = c;
    @(posedge clk);
    #1;
    if (!reset) begin
      model_reset();
    end else begin
      exp_done = last_eof && !c;
      exp_sof = 1'b0; exp_eoc = 1'b0; exp_eof = 1'b0; exp_valid = 1'b0;
      if (c) begin
        k = 0;
      end else if (v) begin
        exp_valid = 1'b1;
        exp_data  = relu(d);
        exp_sof   = (k == 0);
        exp_eoc   = ((k % IS) == IS - 1);
        exp_eof   = (k == FRAME - 1);
        exp_ch    = 8'(k / IS);
        k = (k + 1) % FRAME;
      end
      last_eof = exp_eof;
    end
    check_all();
  endtask

  task automatic beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, $urandom, 1'b0);
      if (gaps) cycle(1'b0, $urandom, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; valid_in = 1'b0; data_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    reset = 1'b1;

    // ReLU corner values, then finish the frame.
    cycle(1'b1, 32'hBF800000, 1'b0);
    cycle(1'b1, 32'h3F800000, 1'b0);
    cycle(1'b1, 32'h80000000, 1'b0);
    cycle(1'b1, 32'hFFC00000, 1'b0);
    beats(4, 1'b0);
    idle(3);

    // Back-to-back frame, gapped frame, then two frames with no gap.
    beats(FRAME, 1'b0);
    idle(3);
    beats(FRAME, 1'b1);
    idle(3);
    beats(2 * FRAME, 1'b0);
    idle(3);

    // Abort with clear on beat 5, then a full fresh frame.
    beats(5, 1'b0);
    cycle(1'b1, $urandom, 1'b1);
    beats(FRAME, 1'b0);
    idle(2);

    // Asynchronous reset mid-frame with beats still arriving.
    beats(5, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    beats(3, 1'b0);
    reset = 1'b1;
    beats(FRAME, 1'b0);
    idle(2);

    // Random traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 10) < 7, $urandom, ($urandom % 32) == 0);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
